register_file: RTL and testbench

- Parametrised successor to the single tri-state register.
- Holds NUM_REGS registers of DATA_BITS each, with one write port and two independently addressed tri-state read ports (A and B).
- The write port supports load, increment and decrement of the target register, so it can host PC/SP-style counters.
- Sits in the datapath and drives the shared ALU operand buses.

---
 rtl/register_file.sv | 131 +++++++++++++
 tb/tb_register_file.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: NUM_REGS x DATA_BITS register file.
// One write port supports load, increment and decrement, which makes it
// suitable for PC/SP-style counters. Two read ports (A and B) drive the
// shared operand buses and release them to Z when disabled.
// All state changes on the falling clock edge. Reset is asynchronous and
// active-high.
// Optional macro REGFILE_BYPASS_EN: the value being written is forwarded
// combinationally to any read port that addresses the write target.
module register_file #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16,
    parameter int ZERO_REG  = 0,
    localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           wr_op,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic [ADDR_BITS-1:0] rd_a_addr,
    input  logic                 rd_a_en,
    output logic [DATA_BITS-1:0] data_out_a,
    input  logic [ADDR_BITS-1:0] rd_b_addr,
    input  logic                 rd_b_en,
    output logic [DATA_BITS-1:0] data_out_b,
    output logic                 wrap
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    // Flat view of every register so the write and read logic can index it.
    logic [NUM_REGS-1:0][DATA_BITS-1:0] regs_all;

    logic [DATA_BITS-1:0] cur_val;
    logic [DATA_BITS-1:0] wr_val;
    logic                 wr_active;
    logic                 wrap_d;
    logic                 wrap_q;

    // Decode the write: the value to store and whether it wraps.
    // A locked register 0 turns every op into a no-op that cannot wrap.
    always_comb begin
        cur_val   = regs_all[wr_addr];
        wr_active = (wr_op != OP_NONE) &&
                    !((ZERO_REG != 0) && (wr_addr == '0));
        wr_val    = cur_val;
        wrap_d    = 1'b0;
        case (wr_op)
            OP_LOAD: wr_val = data_in;
            OP_INC: begin
                wr_val = cur_val + DATA_BITS'(1);
                wrap_d = &cur_val;
            end
            OP_DEC: begin
                wr_val = cur_val - DATA_BITS'(1);
                wrap_d = ~|cur_val;
            end
            default: ;
        endcase
        if (!wr_active) begin
            wrap_d = 1'b0;
        end
    end

    // One storage register per address.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_BITS-1:0] reg_q;
        logic [DATA_BITS-1:0] reg_d;

        // Only the addressed register takes the new value; others hold.
        always_comb begin
            reg_d = reg_q;
            if (wr_active && (wr_addr == ADDR_BITS'(gi))) begin
                reg_d = wr_val;
            end
        end

        // Register storage, cleared asynchronously by reset.
        always_ff @(negedge clk or posedge reset) begin
            if (reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign regs_all[gi] = reg_q;
    end

    // The wrap flag lives for exactly one cycle after the wrapping write.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

    // Read ports: index 0 is port A, index 1 is port B.
    logic [1:0][ADDR_BITS-1:0] rd_addr;
    logic [1:0][DATA_BITS-1:0] rd_val;

    assign rd_addr = {rd_b_addr, rd_a_addr};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        // Combinational read of the current contents (zero-register masked).
        always_comb begin
            rd_val[gi] = regs_all[rd_addr[gi]];
            if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                rd_val[gi] = '0;
            end
`ifdef REGFILE_BYPASS_EN
            // Forward the in-flight write result; wr_active already
            // excludes the locked zero register.
            if (wr_active && (rd_addr[gi] == wr_addr)) begin
                rd_val[gi] = wr_val;
            end
`endif
        end
    end

    // Output enables release the shared buses when a port is idle.
    assign data_out_a = rd_a_en ? rd_val[0] : {DATA_BITS{1'bz}};
    assign data_out_b = rd_b_en ? rd_val[1] : {DATA_BITS{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file. Two instances share all inputs: one with
// ZERO_REG=0 and one with ZERO_REG=1. Each read bus is parked at 0 by the
// bench whenever the matching port is disabled, so a port that fails to
// release the bus shows up as a wrong bus value.
module tb_register_file;

    localparam int DW   = 8;
    localparam int NR   = 16;
    localparam int AW   = 4;
    localparam int DMOD = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    wr_op;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] data_in;
    logic [AW-1:0] rd_a_addr;
    logic          rd_a_en;
    logic [AW-1:0] rd_b_addr;
    logic          rd_b_en;

    wire  [DW-1:0] bus_a0;
    wire  [DW-1:0] bus_b0;
    wire  [DW-1:0] bus_a1;
    wire  [DW-1:0] bus_b1;
    logic          wrap0;
    logic          wrap1;

    int checks   = 0;
    int failures = 0;

    // Reference state: register contents and wrap flag per instance.
    int m  [2][NR];
    int mw [2];

    always #5 clk = ~clk;

    // Bench parks each bus at 0 while the DUT port is disabled.
    assign bus_a0 = rd_a_en ? {DW{1'bz}} : {DW{1'b0}};
    assign bus_b0 = rd_b_en ? {DW{1'bz}} : {DW{1'b0}};
    assign bus_a1 = rd_a_en ? {DW{1'bz}} : {DW{1'b0}};
    assign bus_b1 = rd_b_en ? {DW{1'bz}} : {DW{1'b0}};

    register_file #(.DATA_BITS(DW), .NUM_REGS(NR), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .wr_op(wr_op), .wr_addr(wr_addr),
        .data_in(data_in), .rd_a_addr(rd_a_addr), .rd_a_en(rd_a_en),
        .data_out_a(bus_a0), .rd_b_addr(rd_b_addr), .rd_b_en(rd_b_en),
        .data_out_b(bus_b0), .wrap(wrap0)
    );

    register_file #(.DATA_BITS(DW), .NUM_REGS(NR), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .wr_op(wr_op), .wr_addr(wr_addr),
        .data_in(data_in), .rd_a_addr(rd_a_addr), .rd_a_en(rd_a_en),
        .data_out_a(bus_a1), .rd_b_addr(rd_b_addr), .rd_b_en(rd_b_en),
        .data_out_b(bus_b1), .wrap(wrap1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < NR; r++) m[i][r] = 0;
            mw[i] = 0;
        end
    endtask

    // Value a read port should present given current inputs and model.
    function automatic int exp_rd(int inst, int addr);
        int cur;
        if (inst == 1 && addr == 0) return 0;
        cur = m[inst][addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_op != 2'd0 && addr == int'(wr_addr)) begin
            if (wr_op == 2'd1) return int'(data_in);
            if (wr_op == 2'd2) return (cur + 1) % DMOD;
            return (cur + DMOD - 1) % DMOD;
        end
`endif
        return cur;
    endfunction

    function automatic int exp_bus(int inst, int addr, logic en);
        return en ? exp_rd(inst, addr) : 0;
    endfunction

    task automatic check_reads(input string ph);
        check({ph, "_a0"}, 32'(bus_a0), 32'(exp_bus(0, int'(rd_a_addr), rd_a_en)));
        check({ph, "_b0"}, 32'(bus_b0), 32'(exp_bus(0, int'(rd_b_addr), rd_b_en)));
        check({ph, "_a1"}, 32'(bus_a1), 32'(exp_bus(1, int'(rd_a_addr), rd_a_en)));
        check({ph, "_b1"}, 32'(bus_b1), 32'(exp_bus(1, int'(rd_b_addr), rd_b_en)));
    endtask

    task automatic check_wrap(input string ph);
        check({ph, "_wrap0"}, 32'(wrap0), 32'(mw[0]));
        check({ph, "_wrap1"}, 32'(wrap1), 32'(mw[1]));
    endtask

    // Apply the current write to the model (falling edge, reset low).
    task automatic commit();
        int a;
        int old;
        a = int'(wr_addr);
        for (int i = 0; i < 2; i++) begin
            old   = m[i][a];
            mw[i] = 0;
            if (wr_op != 2'd0 && !(i == 1 && a == 0)) begin
                case (wr_op)
                    2'd1: m[i][a] = int'(data_in);
                    2'd2: begin
                        m[i][a] = (old + 1) % DMOD;
                        mw[i]   = (old == DMOD - 1) ? 1 : 0;
                    end
                    default: begin
                        m[i][a] = (old + DMOD - 1) % DMOD;
                        mw[i]   = (old == 0) ? 1 : 0;
                    end
                endcase
            end
        end
    endtask

    // One transaction: drive after the rising edge, check the same-cycle
    // read, commit on the falling edge, then check results.
    task automatic cycle(input int op, input int addr, input int din,
                         input int ra, input logic rae, input int rb, input logic rbe);
        @(posedge clk);
        #1;
        wr_op     = 2'(op);
        wr_addr   = AW'(addr);
        data_in   = DW'(din);
        rd_a_addr = AW'(ra);
        rd_a_en   = rae;
        rd_b_addr = AW'(rb);
        rd_b_en   = rbe;
        #1;
        check_reads("pre");
        @(negedge clk);
        commit();
        #1;
        check_reads("post");
        check_wrap("post");
        $display("txn op=%0d addr=%0d din=%02h ra=%0d/%0b rb=%0d/%0b a0=%02h b0=%02h a1=%02h b1=%02h wrap=%0b%0b",
                 op, addr, din, ra, rae, rb, rbe, bus_a0, bus_b0, bus_a1, bus_b1, wrap0, wrap1);
    endtask

    initial begin
        int op, addr, din, ra, rb, sel;
        reset = 1'b1; wr_op = 2'd0; wr_addr = '0; data_in = '0;
        rd_a_addr = '0; rd_a_en = 1'b1; rd_b_addr = AW'(5); rd_b_en = 1'b1;
        model_reset();
        #12;
        check_reads("rst");
        check_wrap("rst");
        @(posedge clk); #1; reset = 1'b0;

        // Immediate reset while reg[3] holds 0x5A and port A reads it.
        cycle(1, 3, 'h5A, 3, 1, 0, 0);
        @(posedge clk); #1;
        wr_op = 2'd0;
        #1;
        check_reads("pre_rst");
        reset = 1'b1;
        model_reset();
        #1;
        check_reads("async_rst");
        check_wrap("async_rst");
        @(posedge clk); #1; reset = 1'b0;

        // Load and dual-port read, then port B disabled.
        cycle(1, 7, 'hA5, 7, 1, 7, 1);
        cycle(0, 0, 0, 7, 1, 7, 1);
        cycle(0, 0, 0, 7, 1, 7, 0);

        // Increment wrap, one-cycle pulse, decrement wrap.
        cycle(1, 2, 'hFF, 2, 1, 2, 1);
        cycle(2, 2, 0, 2, 1, 2, 1);
        cycle(0, 0, 0, 2, 1, 2, 1);
        cycle(3, 2, 0, 2, 1, 2, 1);
        cycle(1, 2, 'h11, 2, 1, 2, 1);

        // Register 0 writes (locked on the ZERO_REG instance).
        cycle(1, 0, 'h33, 0, 1, 0, 1);
        cycle(3, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1, 0, 1);

        // Read a register in the same cycle it is loaded.
        cycle(1, 5, 'h10, 5, 1, 5, 0);
        cycle(1, 5, 'h20, 5, 1, 5, 1);

        // Reset asserted together with a load to reg[1].
        @(posedge clk); #1;
        reset = 1'b1; wr_op = 2'd1; wr_addr = AW'(1); data_in = 8'h77;
        rd_a_addr = AW'(3); rd_a_en = 1'b1; rd_b_en = 1'b0;
        model_reset();
        #1;
        check_reads("rst_wr");
        @(negedge clk); #1;
        check_wrap("rst_wr");
        @(posedge clk); #1;
        wr_op = 2'd0; reset = 1'b0;
        cycle(0, 0, 0, 1, 1, 1, 1);

        // Randomized traffic, concentrated on a few addresses to hit wraps.
        for (int n = 0; n < 400; n++) begin
            op   = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1))
                                               : int'($urandom_range(0, 3));
            sel  = int'($urandom_range(0, 5));
            din  = (sel == 0) ? 'hFF : (sel == 1) ? 'h00 : (sel == 2) ? 'h01
                 : int'($urandom_range(0, DMOD - 1));
            ra   = ($urandom_range(0, 1) == 0) ? addr : int'($urandom_range(0, NR - 1));
            rb   = ($urandom_range(0, 1) == 0) ? addr : int'($urandom_range(0, 3));
            cycle(op, addr, din, ra, 1'($urandom_range(0, 3) != 0),
                  rb, 1'($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
